refill_line_buffer: RTL and testbench
=====================================

Name: refill_line_buffer

Overview:
- Parametrised refill buffer between the cache miss path and the memory read-burst port.
- Collects one wrapping burst of word beats, starting at the critical word, into a full cache line.
- Forwards the critical word early and merges a pending miss store using byte enables.
- Hands the assembled line to the cache data/tag write stage through a valid/ready handshake.
- Generalises fixed 8-word line select and 4-bit byte-enable expansion to any word width and line depth.

Parameters:
- WORD_W, 32, data word width in bits; multiple of 8.
- LINE_WORDS, 8, words per cache line; power of two, ≥2.
- OFF_W, $clog2(LINE_WORDS), word-offset width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start_valid  in  1  miss request.
- start_ready  out  1  buffer idle; request accepted when valid&&ready.
- start_offset  in  OFF_W  critical word offset.
- st_en  in  1  miss is a store; merge required.
- st_be  in  WORD_W/8  store byte enables.
- st_data  in  WORD_W  store data (targets word start_offset).
- beat_valid  in  1  memory beat present.
- beat_ready  out  1  buffer accepts beat.
- beat_data  in  WORD_W  beat payload.
- beat_last  in  1  memory marks final beat.
- crit_valid  out  1  one-cycle pulse: critical word available.
- crit_data  out  WORD_W  critical word, after store merge.
- line_valid  out  1  full line ready.
- line_ready  in  1  cache consumes line.
- line_data  out  WORD_W*LINE_WORDS  assembled line; word i at bits [i*WORD_W +: WORD_W].
- proto_err  out  1  one-cycle pulse on burst length mismatch.

Behaviour:
- States: IDLE, FILL, DONE. Reset → IDLE.
- Reset values: all outputs 0 except start_ready=1; line storage, pointer, count and captured store registers cleared to 0.
- IDLE:
  - start_ready=1, beat_ready=0.
  - On start handshake, capture start_offset into ptr and crit_off, and capture st_en/st_be/st_data; set cnt=0; go to FILL.
- FILL:
  - beat_ready=1, start_ready=0.
  - Each beat handshake writes word[ptr]; then ptr = (ptr+1) mod LINE_WORDS (wrap-around) and cnt = cnt+1.
  - Store merge on the beat where ptr==crit_off and st_en: byte b = st_be[b] ? st_data byte b : beat_data byte b.
  - The critical word is always the first beat. crit_valid pulses in the cycle after that beat's handshake, with crit_data = merged word. Latency is 1 cycle.
  - The beat with cnt==LINE_WORDS-1 ends the fill: go to DONE.
  - beat_last on an earlier beat: pulse proto_err, ignore the flag, keep filling.
  - beat_last absent on the final beat: pulse proto_err, go to DONE anyway.
  - Extra beats are never accepted, because beat_ready=0 outside FILL.
- DONE:
  - line_valid=1, held stable until line_ready; line_data stable while line_valid.
  - On the line handshake: line_valid drops next cycle, go to IDLE, start_ready=1.
  - A new start is not accepted in the same cycle as the line handshake.
- beat_valid low in FILL: stall with no state change; no timeout.
- rst asserted mid-FILL or mid-DONE: immediate return to IDLE, partial line discarded, no crit_valid/line_valid/proto_err generated.
- crit_valid and line_valid may coincide only when LINE_WORDS... they never coincide for LINE_WORDS≥2: crit_valid fires after beat 0, line_valid after the last beat.

Optional Feature:
- Macro: REFILL_STORE_MERGE_EN.
- Defined: store merge as above.
- Undefined:
  - st_en/st_be/st_data are ignored and their capture registers are not built.
  - Line and critical word equal raw beat data; the cache applies the store itself after refill.
- Port list is identical in both builds.

Decomposition:
- Shared cache package holds:
  - refill state enum (IDLE/FILL/DONE);
  - default WORD_W and LINE_WORDS constants;
  - a byte-merge function (old word, new word, byte enables → word).
- One natural sub-module, byte_merge, a parametrised combinational byte-enable merge. It is reusable by the store-buffer path.
- Word insertion into line storage is an indexed write; no separate decoder module.

Test Plan:
- start_offset=0, no store, 8 beats 0x100..0x107 with last on beat 7 → crit_data=0x100 one cycle after beat 0; line word i=0x100+i; proto_err stays 0.
- start_offset=5, beats 0xA5,0xA6,0xA7,0xA0..0xA4 → wrap-around fills word5=0xA5 … word4=0xA4; crit_valid after first beat with crit_data=0xA5.
- start_offset=3, st_en=1, st_be=4'b0101, st_data=0xDEADBEEF, beat0=0x11223344 → crit_data and word3=0x11AD33EF. Without REFILL_STORE_MERGE_EN: 0x11223344.
- beat_last on beat 2, then absent on beat 7 → proto_err pulses twice, line still completes after 8 beats.
- Full line with line_ready held low 10 cycles → line_valid and line_data stable, beat_ready=0, start_ready=0; clears one cycle after line_ready.
- rst pulse after beat 4 of 8 → next cycle start_ready=1, line_valid=0; a fresh refill completes with correct data.

Source files
------------

// File: rtl/refill_line_buffer_pkg.sv
// Shared cache refill definitions: FSM state encoding, default line geometry
// and a byte-enable merge helper for default-width words.
package refill_line_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } refill_state_e;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_LINE_WORDS = 8;

  function automatic logic [DEF_WORD_W-1:0] merge_bytes(
    input logic [DEF_WORD_W-1:0]   old_word,
    input logic [DEF_WORD_W-1:0]   new_word,
    input logic [DEF_WORD_W/8-1:0] be
  );
    logic [DEF_WORD_W-1:0] res;
    res = old_word;
    for (int b = 0; b < DEF_WORD_W/8; b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/refill_line_buffer_byte_merge.sv
// Combinational byte-enable merge: bytes with be set come from new_word,
// all others from old_word. Shared with the store-buffer path.
module byte_merge #(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0]   old_word,
  input  logic [WORD_W-1:0]   new_word,
  input  logic [WORD_W/8-1:0] be,
  output logic [WORD_W-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int b = 0; b < WORD_W/8; b++) begin
      if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
  end

endmodule

// File: rtl/refill_line_buffer.sv
// Refill line buffer: assembles a wrapping read burst into a cache line and
// forwards the critical word. Store merge is built only with REFILL_STORE_MERGE_EN.
module refill_line_buffer
  import refill_line_buffer_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [OFF_W-1:0]             start_offset,
  input  logic                         st_en,
  input  logic [WORD_W/8-1:0]          st_be,
  input  logic [WORD_W-1:0]            st_data,
  input  logic                         beat_valid,
  output logic                         beat_ready,
  input  logic [WORD_W-1:0]            beat_data,
  input  logic                         beat_last,
  output logic                         crit_valid,
  output logic [WORD_W-1:0]            crit_data,
  output logic                         line_valid,
  input  logic                         line_ready,
  output logic [WORD_W*LINE_WORDS-1:0] line_data,
  output logic                         proto_err
);

  localparam int               BE_W     = WORD_W/8;
  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS-1);

  refill_state_e     state;
  logic [OFF_W-1:0]  ptr;
  logic [OFF_W-1:0]  cnt;
  logic [WORD_W-1:0] line_mem [LINE_WORDS];
  logic [WORD_W-1:0] wr_word;

`ifdef REFILL_STORE_MERGE_EN
  logic              st_en_q;
  logic [BE_W-1:0]   st_be_q;
  logic [WORD_W-1:0] st_data_q;
  logic [OFF_W-1:0]  crit_off;
  logic [WORD_W-1:0] merged_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_en_q   <= 1'b0;
      st_be_q   <= '0;
      st_data_q <= '0;
      crit_off  <= '0;
    end else if (state == ST_IDLE && start_valid && start_ready) begin
      st_en_q   <= st_en;
      st_be_q   <= st_be;
      st_data_q <= st_data;
      crit_off  <= start_offset;
    end
  end

  byte_merge #(.WORD_W(WORD_W)) u_byte_merge (
    .old_word (beat_data),
    .new_word (st_data_q),
    .be       (st_be_q),
    .merged   (merged_word)
  );

  assign wr_word = (st_en_q && ptr == crit_off) ? merged_word : beat_data;
`else
  // The cache applies the miss store itself after refill in this build.
  logic unused_store;
  assign unused_store = ^{st_en, st_be, st_data};
  assign wr_word      = beat_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      start_ready <= 1'b1;
      beat_ready  <= 1'b0;
      line_valid  <= 1'b0;
      crit_valid  <= 1'b0;
      crit_data   <= '0;
      proto_err   <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) line_mem[i] <= '0;
    end else begin
      crit_valid <= 1'b0;
      proto_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_valid && start_ready) begin
            ptr         <= start_offset;
            cnt         <= '0;
            start_ready <= 1'b0;
            beat_ready  <= 1'b1;
            state       <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (beat_valid && beat_ready) begin
            line_mem[ptr] <= wr_word;
            ptr           <= ptr + OFF_W'(1);
            cnt           <= cnt + OFF_W'(1);
            // The burst always opens with the critical word.
            if (cnt == '0) begin
              crit_valid <= 1'b1;
              crit_data  <= wr_word;
            end
            if (cnt == LAST_CNT) begin
              proto_err  <= ~beat_last;
              beat_ready <= 1'b0;
              line_valid <= 1'b1;
              state      <= ST_DONE;
            end else begin
              proto_err  <= beat_last;
            end
          end
        end
        ST_DONE: begin
          if (line_valid && line_ready) begin
            line_valid  <= 1'b0;
            start_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    line_data = '0;
    for (int i = 0; i < LINE_WORDS; i++) line_data[i*WORD_W +: WORD_W] = line_mem[i];
  end

endmodule

// File: tb/tb_refill_line_buffer.sv
// Testbench for refill_line_buffer: directed and randomized refills checked
// against a line-level reference model (wrap-around placement plus store merge).
module tb_refill_line_buffer;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 8;
  localparam int OFF_W      = 3;
  localparam int BE_W       = WORD_W/8;
`ifdef REFILL_STORE_MERGE_EN
  localparam bit MERGE_ON = 1'b1;
`else
  localparam bit MERGE_ON = 1'b0;
`endif

  logic                         clk;
  logic                         rst;
  logic                         start_valid;
  logic                         start_ready;
  logic [OFF_W-1:0]             start_offset;
  logic                         st_en;
  logic [BE_W-1:0]              st_be;
  logic [WORD_W-1:0]            st_data;
  logic                         beat_valid;
  logic                         beat_ready;
  logic [WORD_W-1:0]            beat_data;
  logic                         beat_last;
  logic                         crit_valid;
  logic [WORD_W-1:0]            crit_data;
  logic                         line_valid;
  logic                         line_ready;
  logic [WORD_W*LINE_WORDS-1:0] line_data;
  logic                         proto_err;

  refill_line_buffer #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .start_offset(start_offset),
    .st_en(st_en), .st_be(st_be), .st_data(st_data),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data), .beat_last(beat_last),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [WORD_W-1:0]     stim_beats [LINE_WORDS];
  logic [LINE_WORDS-1:0] stim_last;
  logic [WORD_W-1:0]     exp_line [LINE_WORDS];
  logic [WORD_W-1:0]     exp_crit;

  int                    obs_crit_pulses;
  int                    obs_crit_beat;
  logic [WORD_W-1:0]     obs_crit_data;
  logic [LINE_WORDS-1:0] obs_perr;
  int                    obs_lv_early;
  logic                  obs_lv_final;
  logic                  obs_start_ok;

  // Reference: beat i lands in slot (off+i) mod LINE_WORDS; a store patches
  // the critical slot byte by byte when merge is built in.
  task automatic model_line(input int off, input logic sen, input logic [BE_W-1:0] be,
                            input logic [WORD_W-1:0] sd);
    for (int i = 0; i < LINE_WORDS; i++) exp_line[(off + i) % LINE_WORDS] = stim_beats[i];
    if (MERGE_ON && sen) begin
      for (int b = 0; b < BE_W; b++)
        if (be[b]) exp_line[off][b*8 +: 8] = sd[b*8 +: 8];
    end
    exp_crit = exp_line[off];
  endtask

  task automatic start_refill(input logic [OFF_W-1:0] off, input logic sen,
                              input logic [BE_W-1:0] be, input logic [WORD_W-1:0] sd);
    int n;
    n = 0;
    start_valid = 1'b1; start_offset = off; st_en = sen; st_be = be; st_data = sd;
    while (!start_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    obs_start_ok = start_ready;
    @(posedge clk); #1;
    start_valid = 1'b0; start_offset = OFF_W'($urandom);
    st_en = 1'b0; st_be = BE_W'($urandom); st_data = $urandom;
  endtask

  task automatic feed_beats(input int max_stall, input int n_beats);
    int stall;
    obs_crit_pulses = 0; obs_crit_beat = -1; obs_crit_data = '0;
    obs_perr = '0; obs_lv_early = 0; obs_lv_final = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
      repeat (stall) begin
        @(posedge clk); #1;
        if (crit_valid) obs_crit_pulses++;
      end
      beat_valid = 1'b1; beat_data = stim_beats[i]; beat_last = stim_last[i];
      @(posedge clk); #1;
      beat_valid = 1'b0; beat_last = 1'b0; beat_data = $urandom;
      if (crit_valid) begin
        obs_crit_pulses++;
        if (obs_crit_beat < 0) begin
          obs_crit_beat = i;
          obs_crit_data = crit_data;
        end
      end
      obs_perr[i] = proto_err;
      if (line_valid && i < LINE_WORDS-1) obs_lv_early++;
      if (i == LINE_WORDS-1) obs_lv_final = line_valid;
    end
  endtask

  task automatic take_line(input int delay);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    line_ready = 1'b1;
    @(posedge clk); #1;
    line_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got=%0b want=1", start_ready); end
    checks++; if (beat_ready !== 1'b0) begin errors++; $display("FAIL reset_beat_ready got=%0b want=0", beat_ready); end
    checks++; if ({line_valid, crit_valid, proto_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b want=000", {line_valid, crit_valid, proto_err}); end
    checks++; if (line_data !== '0 || crit_data !== '0) begin errors++; $display("FAIL reset_data line=%h crit=%h want zero", line_data, crit_data); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (start_ready !== 1'b1 || beat_ready !== 1'b0) begin errors++; $display("FAIL idle_after_reset start_ready=%0b beat_ready=%0b want 1/0", start_ready, beat_ready); end
  endtask

  task automatic test_in_order();
    for (int i = 0; i < LINE_WORDS; i++) stim_beats[i] = 32'h100 + i;
    stim_last = 8'h80;
    start_refill(3'd0, 1'b0, 4'h0, 32'h0);
    checks++; if (obs_start_ok !== 1'b1 || beat_ready !== 1'b1 || start_ready !== 1'b0) begin errors++; $display("FAIL inorder_fill_entry start_ok=%0b beat_ready=%0b start_ready=%0b want 1/1/0", obs_start_ok, beat_ready, start_ready); end
    feed_beats(0, LINE_WORDS);
    checks++; if (obs_crit_beat != 0 || obs_crit_pulses != 1) begin errors++; $display("FAIL inorder_crit_timing beat=%0d pulses=%0d want 0/1", obs_crit_beat, obs_crit_pulses); end
    checks++; if (obs_crit_data !== 32'h100) begin errors++; $display("FAIL inorder_crit_data got=%h want=00000100", obs_crit_data); end
    checks++; if (obs_perr !== 8'h00) begin errors++; $display("FAIL inorder_proto_err got=%b want=00000000", obs_perr); end
    checks++; if (obs_lv_final !== 1'b1 || obs_lv_early != 0) begin errors++; $display("FAIL inorder_line_valid final=%0b early=%0d want 1/0", obs_lv_final, obs_lv_early); end
    for (int i = 0; i < LINE_WORDS; i++) begin
      checks++; if (line_data[i*WORD_W +: WORD_W] !== 32'h100 + i) begin errors++; $display("FAIL inorder_word%0d got=%h want=%h", i, line_data[i*WORD_W +: WORD_W], 32'h100 + i); end
    end
    take_line(0);
    checks++; if (line_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL inorder_release line_valid=%0b start_ready=%0b want 0/1", line_valid, start_ready); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < LINE_WORDS; i++) stim_beats[i] = 32'hA0 + ((5 + i) % LINE_WORDS);
    stim_last = 8'h80;
    start_refill(3'd5, 1'b0, 4'h0, 32'h0);
    feed_beats(2, LINE_WORDS);
    checks++; if (obs_crit_beat != 0 || obs_crit_data !== 32'hA5) begin errors++; $display("FAIL wrap_crit beat=%0d data=%h want 0/000000a5", obs_crit_beat, obs_crit_data); end
    for (int i = 0; i < LINE_WORDS; i++) begin
      checks++; if (line_data[i*WORD_W +: WORD_W] !== 32'hA0 + i) begin errors++; $display("FAIL wrap_word%0d got=%h want=%h", i, line_data[i*WORD_W +: WORD_W], 32'hA0 + i); end
    end
    take_line(1);
  endtask

  task automatic test_store_merge();
    logic [WORD_W-1:0] want;
    want = MERGE_ON ? 32'h11AD33EF : 32'h11223344;
    stim_beats[0] = 32'h11223344;
    for (int i = 1; i < LINE_WORDS; i++) stim_beats[i] = $urandom;
    stim_last = 8'h80;
    start_refill(3'd3, 1'b1, 4'b0101, 32'hDEADBEEF);
    model_line(3, 1'b1, 4'b0101, 32'hDEADBEEF);
    feed_beats(1, LINE_WORDS);
    checks++; if (obs_crit_data !== want) begin errors++; $display("FAIL merge_crit got=%h want=%h", obs_crit_data, want); end
    checks++; if (line_data[3*WORD_W +: WORD_W] !== want) begin errors++; $display("FAIL merge_word3 got=%h want=%h", line_data[3*WORD_W +: WORD_W], want); end
    for (int i = 0; i < LINE_WORDS; i++) begin
      checks++; if (line_data[i*WORD_W +: WORD_W] !== exp_line[i]) begin errors++; $display("FAIL merge_word%0d got=%h want=%h", i, line_data[i*WORD_W +: WORD_W], exp_line[i]); end
    end
    take_line(0);
  endtask

  task automatic test_proto_err();
    for (int i = 0; i < LINE_WORDS; i++) stim_beats[i] = $urandom;
    stim_last = 8'h04;
    start_refill(3'd6, 1'b0, 4'h0, 32'h0);
    model_line(6, 1'b0, 4'h0, 32'h0);
    feed_beats(1, LINE_WORDS);
    checks++; if (obs_perr !== 8'h84) begin errors++; $display("FAIL perr_pulses got=%b want=10000100", obs_perr); end
    checks++; if (obs_lv_final !== 1'b1 || obs_lv_early != 0) begin errors++; $display("FAIL perr_line_valid final=%0b early=%0d want 1/0", obs_lv_final, obs_lv_early); end
    for (int i = 0; i < LINE_WORDS; i++) begin
      checks++; if (line_data[i*WORD_W +: WORD_W] !== exp_line[i]) begin errors++; $display("FAIL perr_word%0d got=%h want=%h", i, line_data[i*WORD_W +: WORD_W], exp_line[i]); end
    end
    take_line(0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < LINE_WORDS; i++) stim_beats[i] = $urandom;
    stim_last = 8'h80;
    start_refill(3'd2, 1'b0, 4'h0, 32'h0);
    model_line(2, 1'b0, 4'h0, 32'h0);
    feed_beats(0, LINE_WORDS);
    // Offer stray beats and a new request while the line waits.
    beat_valid = 1'b1; beat_last = 1'b1; start_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      beat_data = $urandom;
      @(posedge clk); #1;
      checks++; if (line_valid !== 1'b1) begin errors++; $display("FAIL hold_line_valid cyc=%0d got=%0b want=1", c, line_valid); end
      checks++; if (beat_ready !== 1'b0 || start_ready !== 1'b0) begin errors++; $display("FAIL hold_ready cyc=%0d beat_ready=%0b start_ready=%0b want 0/0", c, beat_ready, start_ready); end
      for (int i = 0; i < LINE_WORDS; i++) begin
        checks++; if (line_data[i*WORD_W +: WORD_W] !== exp_line[i]) begin errors++; $display("FAIL hold_word%0d cyc=%0d got=%h want=%h", i, c, line_data[i*WORD_W +: WORD_W], exp_line[i]); end
      end
    end
    beat_valid = 1'b0; beat_last = 1'b0;
    line_ready = 1'b1;
    @(posedge clk); #1;
    line_ready = 1'b0;
    checks++; if (line_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL hold_release line_valid=%0b start_ready=%0b want 0/1", line_valid, start_ready); end
    start_valid = 1'b0;
    checks++; if (beat_ready !== 1'b0) begin errors++; $display("FAIL hold_no_same_cycle_start beat_ready=%0b want=0", beat_ready); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < LINE_WORDS; i++) stim_beats[i] = $urandom;
    stim_last = 8'h80;
    start_refill(3'd1, 1'b1, 4'hF, 32'hCAFEF00D);
    feed_beats(0, 4);
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (start_ready !== 1'b1 || beat_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready start_ready=%0b beat_ready=%0b want 1/0", start_ready, beat_ready); end
    checks++; if ({line_valid, crit_valid, proto_err} !== 3'b000) begin errors++; $display("FAIL midrst_pulses got=%b want=000", {line_valid, crit_valid, proto_err}); end
    checks++; if (line_data !== '0) begin errors++; $display("FAIL midrst_line_cleared got=%h want=0", line_data); end
    for (int i = 0; i < LINE_WORDS; i++) stim_beats[i] = $urandom;
    start_refill(3'd7, 1'b0, 4'h0, 32'h0);
    model_line(7, 1'b0, 4'h0, 32'h0);
    feed_beats(1, LINE_WORDS);
    checks++; if (obs_crit_data !== exp_crit || obs_lv_final !== 1'b1) begin errors++; $display("FAIL midrst_refill crit=%h lv=%0b want %h/1", obs_crit_data, obs_lv_final, exp_crit); end
    for (int i = 0; i < LINE_WORDS; i++) begin
      checks++; if (line_data[i*WORD_W +: WORD_W] !== exp_line[i]) begin errors++; $display("FAIL midrst_word%0d got=%h want=%h", i, line_data[i*WORD_W +: WORD_W], exp_line[i]); end
    end
    take_line(0);
  endtask

  task automatic test_random();
    logic [OFF_W-1:0]      off;
    logic                  sen;
    logic [BE_W-1:0]       be;
    logic [WORD_W-1:0]     sd;
    logic [LINE_WORDS-1:0] exp_perr;
    for (int t = 0; t < 12; t++) begin
      off = OFF_W'($urandom); sen = 1'($urandom); be = BE_W'($urandom); sd = $urandom;
      for (int i = 0; i < LINE_WORDS; i++) stim_beats[i] = $urandom;
      stim_last = ($urandom_range(0, 3) == 0) ? LINE_WORDS'($urandom) : 8'h80;
      for (int i = 0; i < LINE_WORDS; i++)
        exp_perr[i] = (i == LINE_WORDS-1) ? ~stim_last[i] : stim_last[i];
      start_refill(off, sen, be, sd);
      model_line(int'(off), sen, be, sd);
      feed_beats(3, LINE_WORDS);
      checks++; if (obs_crit_beat != 0 || obs_crit_pulses != 1 || obs_crit_data !== exp_crit) begin errors++; $display("FAIL rand%0d_crit beat=%0d pulses=%0d data=%h want 0/1/%h", t, obs_crit_beat, obs_crit_pulses, obs_crit_data, exp_crit); end
      checks++; if (obs_perr !== exp_perr) begin errors++; $display("FAIL rand%0d_perr got=%b want=%b", t, obs_perr, exp_perr); end
      checks++; if (obs_lv_final !== 1'b1 || obs_lv_early != 0) begin errors++; $display("FAIL rand%0d_line_valid final=%0b early=%0d want 1/0", t, obs_lv_final, obs_lv_early); end
      for (int i = 0; i < LINE_WORDS; i++) begin
        checks++; if (line_data[i*WORD_W +: WORD_W] !== exp_line[i]) begin errors++; $display("FAIL rand%0d_word%0d got=%h want=%h", t, i, line_data[i*WORD_W +: WORD_W], exp_line[i]); end
      end
      take_line(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_valid = 1'b0; start_offset = '0; st_en = 1'b0; st_be = '0; st_data = '0;
    beat_valid = 1'b0; beat_data = '0; beat_last = 1'b0; line_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_in_order();
    test_wrap();
    test_store_merge();
    test_proto_err();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
